// File: rtl/branch_pc_unit.sv
// Program counter and branch sequencer.
// Fetch increment, conditional branch, jump-register and jump-and-link.
module branch_pc_unit #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter int          OFFSET_W = 19
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                fetch_inc,
  input  logic                start_br,
  input  logic                start_jr,
  input  logic                start_jal,
  input  logic [1:0]          br_type,
  input  logic [OFFSET_W-1:0] br_offset,
  input  logic [31:0]         ra_value,
  input  logic                con_in,
  output logic [31:0]         pc,
  output logic [1:0]          cond_sel,
  output logic                con_eval,
  output logic                link_we,
  output logic [31:0]         link_data,
  output logic                busy,
  output logic                done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EVAL,
    S_SAMPLE,
    S_LINK,
    S_DONE
  } state_t;

  state_t      state;
  logic [31:0] off_q;
  logic [31:0] ra_q;
  logic [31:0] off_ext;

  assign off_ext = {{(32-OFFSET_W){br_offset[OFFSET_W-1]}}, br_offset};

  // Handshake outputs decode straight from the state register
  assign busy     = (state != S_IDLE);
  assign con_eval = (state == S_EVAL);
  assign link_we  = (state == S_LINK);
  assign done     = (state == S_DONE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      pc        <= PC_RESET;
      cond_sel  <= 2'b00;
      link_data <= 32'd0;
      off_q     <= 32'd0;
      ra_q      <= 32'd0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start_br) begin
            state    <= S_EVAL;
            cond_sel <= br_type;
            off_q    <= off_ext;
          end else if (start_jal) begin
            state     <= S_LINK;
            link_data <= pc;
            ra_q      <= ra_value;
          end else if (start_jr) begin
            state <= S_DONE;
            pc    <= ra_value;
          end else if (fetch_inc) begin
            pc <= pc + 32'd1;
          end
        end
        S_EVAL: begin
          state <= S_SAMPLE;
        end
        S_SAMPLE: begin
          if (con_in) pc <= pc + off_q;
          state <= S_DONE;
        end
        S_LINK: begin
          pc    <= ra_q;
          state <= S_DONE;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
